// File: rtl/md_pkg.sv
// Shared constants and FSM encoding for the market-data frame parser.
package md_pkg;

  localparam logic [7:0] SOF_DEFAULT   = 8'hA5;
  localparam int         PAYLOAD_BYTES = 16;
  localparam int         LAST_IDX      = PAYLOAD_BYTES - 1;

  // Field slots in the payload, in wire order.
  localparam logic [1:0] BUYP  = 2'd0;
  localparam logic [1:0] SELLP = 2'd1;
  localparam logic [1:0] BUYV  = 2'd2;
  localparam logic [1:0] SELLV = 2'd3;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ADDR    = 2'd1,
    PAYLOAD = 2'd2,
    CKSUM   = 2'd3
  } md_state_e;

endpackage

// File: rtl/md_sat_counter.sv
// Saturating up-counter used for the parser's drop statistics.
module md_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours regardless of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     count <= '0;
    else if (inc && (count != '1)) count <= count + 1'b1;
  end

endmodule

// File: rtl/md_frame_parser.sv
// Quote-frame parser: hunts SOF, reassembles big-endian fields, commits good frames.
// Build option: define MD_CHECKSUM_EN for 19-byte frames with a trailing XOR checksum.
module md_frame_parser
  import md_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE    = SOF_DEFAULT,
  parameter int         TIMEOUT_CYC = 64,
  parameter int         ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           in_byte,
  input  logic                 in_valid,
  output logic [7:0]           addr0,
  output logic [31:0]          rx_buyprice0,
  output logic [31:0]          rx_sellprice0,
  output logic [31:0]          rx_buyvol0,
  output logic [31:0]          rx_sellvol0,
  output logic                 rx_dv0,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_cksum_cnt,
  output logic [ERR_CNT_W-1:0] err_timeout_cnt
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

  md_state_e         state, state_nxt;
  logic [3:0]        byte_idx;
  logic [7:0]        addr_sh;
  logic [3:0][31:0]  field_sh;
  logic [IDLE_W-1:0] idle_cnt;
  logic              timeout_hit;
  logic              commit;
  logic [31:0]       sellvol_final;

  assign busy        = (state != HUNT);
  assign timeout_hit = busy && !in_valid && (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

`ifdef MD_CHECKSUM_EN
  logic [7:0] ck;
  logic       cksum_fail;

  assign commit        = (state == CKSUM) && in_valid && (in_byte == ck);
  assign cksum_fail    = (state == CKSUM) && in_valid && (in_byte != ck);
  assign sellvol_final = field_sh[SELLV];
`else
  // Without a checksum the last payload byte commits directly, so merge it on the fly.
  assign commit        = (state == PAYLOAD) && in_valid && (byte_idx == 4'(LAST_IDX));
  assign sellvol_final = {field_sh[SELLV][23:0], in_byte};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= HUNT;
    else       state <= state_nxt;
  end

  // NOTE: state_nxt gets its default before any branch so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (timeout_hit) begin
      state_nxt = HUNT;
    end else if (in_valid) begin
      case (state)
        HUNT:    if (in_byte == SOF_BYTE) state_nxt = ADDR;
        ADDR:    state_nxt = PAYLOAD;
        PAYLOAD: begin
          if (byte_idx == 4'(LAST_IDX)) begin
`ifdef MD_CHECKSUM_EN
            state_nxt = CKSUM;
`else
            state_nxt = HUNT;
`endif
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // NOTE: the shadow registers are reset along with everything else so a frame torn
  // by reset can never leak stale bytes into a later commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx      <= '0;
      addr_sh       <= '0;
      field_sh      <= '0;
      idle_cnt      <= '0;
      addr0         <= '0;
      rx_buyprice0  <= '0;
      rx_sellprice0 <= '0;
      rx_buyvol0    <= '0;
      rx_sellvol0   <= '0;
      rx_dv0        <= 1'b0;
`ifdef MD_CHECKSUM_EN
      ck            <= '0;
`endif
    end else begin
      rx_dv0 <= commit;

      if (in_valid || !busy || timeout_hit) idle_cnt <= '0;
      else                                  idle_cnt <= idle_cnt + 1'b1;

      if (in_valid) begin
        case (state)
          ADDR: begin
            addr_sh  <= in_byte;
            byte_idx <= '0;
`ifdef MD_CHECKSUM_EN
            ck       <= in_byte;
`endif
          end
          PAYLOAD: begin
            field_sh[byte_idx[3:2]] <= {field_sh[byte_idx[3:2]][23:0], in_byte};
            byte_idx                <= byte_idx + 4'd1;
`ifdef MD_CHECKSUM_EN
            ck                      <= ck ^ in_byte;
`endif
          end
          default: ;
        endcase
      end

      if (commit) begin
        addr0         <= addr_sh;
        rx_buyprice0  <= field_sh[BUYP];
        rx_sellprice0 <= field_sh[SELLP];
        rx_buyvol0    <= field_sh[BUYV];
        rx_sellvol0   <= sellvol_final;
      end
    end
  end

  md_sat_counter #(.WIDTH(ERR_CNT_W)) u_timeout_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (timeout_hit),
    .count (err_timeout_cnt)
  );

`ifdef MD_CHECKSUM_EN
  md_sat_counter #(.WIDTH(ERR_CNT_W)) u_cksum_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (cksum_fail),
    .count (err_cksum_cnt)
  );
`else
  assign err_cksum_cnt = '0;
`endif

endmodule

// File: tb/tb_md_frame_parser.sv
// Randomized self-checking bench for md_frame_parser against a frame-level scoreboard.
// Honours MD_CHECKSUM_EN the same way as the design.
module tb_md_frame_parser;

`ifdef MD_CHECKSUM_EN
  localparam bit CK_EN     = 1'b1;
  localparam int FRAME_LEN = 19;
`else
  localparam bit CK_EN     = 1'b0;
  localparam int FRAME_LEN = 18;
`endif

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  addr;
    logic [31:0] bp;
    logic [31:0] sp;
    logic [31:0] bv;
    logic [31:0] sv;
  } quote_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic [7:0]  addr0;
  logic [31:0] rx_buyprice0, rx_sellprice0, rx_buyvol0, rx_sellvol0;
  logic        rx_dv0, busy;
  logic [15:0] err_cksum_cnt, err_timeout_cnt;

  md_frame_parser dut (
    .clk             (clk),
    .reset           (reset),
    .in_byte         (in_byte),
    .in_valid        (in_valid),
    .addr0           (addr0),
    .rx_buyprice0    (rx_buyprice0),
    .rx_sellprice0   (rx_sellprice0),
    .rx_buyvol0      (rx_buyvol0),
    .rx_sellvol0     (rx_sellvol0),
    .rx_dv0          (rx_dv0),
    .busy            (busy),
    .err_cksum_cnt   (err_cksum_cnt),
    .err_timeout_cnt (err_timeout_cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          exp_ck_errs, exp_to_errs;
  int unsigned last_drive_cyc;
  quote_t      cur, last_good;
  quote_t      got_q[$], exp_q[$];
  logic [7:0]  frame_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk)
    if (!reset && rx_dv0)
      got_q.push_back('{cyc: cyc, addr: addr0, bp: rx_buyprice0, sp: rx_sellprice0,
                        bv: rx_buyvol0, sv: rx_sellvol0});

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    in_byte        = b;
    in_valid       = 1'b1;
    last_drive_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_byte  = 8'($urandom);
    end
  endtask

  // Serialises cur into frame_q; bad flips one checksum bit.
  task automatic make_frame(input bit bad);
    logic [31:0] fv[4];
    logic [7:0]  ck, b;
    fv = '{cur.bp, cur.sp, cur.bv, cur.sv};
    frame_q.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(cur.addr);
    ck = cur.addr;
    for (int f = 0; f < 4; f++)
      for (int k = 3; k >= 0; k--) begin
        b = fv[f][8*k +: 8];
        frame_q.push_back(b);
        ck ^= b;
      end
    if (CK_EN) frame_q.push_back(ck ^ {7'd0, bad});
  endtask

  task automatic rand_fields();
    cur = '{cyc: 0, addr: 8'($urandom), bp: $urandom, sp: $urandom, bv: $urandom, sv: $urandom};
  endtask

  // Sends bytes [from, size) with random gaps; the model records the outcome at the end.
  task automatic send_from(input int from, input int max_gap, input bit bad);
    for (int i = from; i < frame_q.size(); i++) begin
      if (i > from && max_gap > 0) idle($urandom_range(max_gap, 0));
      send_byte(frame_q[i]);
    end
    if (bad) exp_ck_errs++;
    else begin
      cur.cyc = last_drive_cyc + 1;
      exp_q.push_back(cur);
      last_good = cur;
    end
  endtask

  task automatic flush_and_compare(input string tag);
    int n;
    idle(4);
    check({tag, ".dv_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, ".dv_cycle"}, 64'(got_q[i].cyc), 64'(exp_q[i].cyc));
      check({tag, ".addr"}, 64'(got_q[i].addr), 64'(exp_q[i].addr));
      check({tag, ".prices"}, {got_q[i].bp, got_q[i].sp}, {exp_q[i].bp, exp_q[i].sp});
      check({tag, ".vols"}, {got_q[i].bv, got_q[i].sv}, {exp_q[i].bv, exp_q[i].sv});
    end
    check({tag, ".held_addr"}, 64'(addr0), 64'(last_good.addr));
    check({tag, ".held_data"}, {rx_buyprice0, rx_sellvol0}, {last_good.bp, last_good.sv});
    check({tag, ".err_cksum"}, 64'(err_cksum_cnt), 64'(exp_ck_errs));
    check({tag, ".err_timeout"}, 64'(err_timeout_cnt), 64'(exp_to_errs));
    check({tag, ".busy"}, 64'(busy), 64'd0);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".addr0"}, 64'(addr0), 64'd0);
    check({tag, ".prices"}, {rx_buyprice0, rx_sellprice0}, 64'd0);
    check({tag, ".vols"}, {rx_buyvol0, rx_sellvol0}, 64'd0);
    check({tag, ".dv_busy"}, {62'd0, rx_dv0, busy}, 64'd0);
    check({tag, ".errs"}, {err_cksum_cnt, err_timeout_cnt}, 64'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    exp_ck_errs = 0;
    exp_to_errs = 0;
    last_good   = '0;
    got_q.delete();
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] junk[3];
    logic [7:0] jb;
    logic [31:0] t0, t1;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_byte  = 8'h00;

    // 1: reset values, then the reference frame.
    apply_reset();
    check_reset_state("reset");
    reset = 1'b0;
    cur = '{cyc: 0, addr: 8'h07, bp: 32'd100, sp: 32'd101, bv: 32'd1000, sv: 32'd2000};
    make_frame(1'b0);
    send_from(0, 0, 1'b0);
    flush_and_compare("basic");

    // 2: corrupted checksum is dropped and counted.
    if (CK_EN) begin
      rand_fields();
      make_frame(1'b1);
      send_from(0, 0, 1'b1);
      flush_and_compare("bad_cksum");
    end

    // 3: junk before SOF, SOF values inside the frame.
    junk = '{8'h00, 8'hFF, 8'h12};
    foreach (junk[i]) send_byte(junk[i]);
    cur = '{cyc: 0, addr: 8'hA5, bp: 32'hA5A5_0001, sp: $urandom, bv: 32'h00A5_0000, sv: $urandom};
    make_frame(1'b0);
    send_from(0, 1, 1'b0);
    flush_and_compare("junk_sof");

    // 4: 64-cycle stall aborts, 63-cycle stall does not.
    rand_fields();
    make_frame(1'b0);
    for (int i = 0; i < 8; i++) send_byte(frame_q[i]);
    idle(63);
    check("stall62.busy", 64'(busy), 64'd1);
    idle(1);
    check("stall63.busy", 64'(busy), 64'd1);
    idle(1);
    exp_to_errs++;
    check("stall64.busy", 64'(busy), 64'd0);
    check("stall64.err_timeout", 64'(err_timeout_cnt), 64'(exp_to_errs));
    flush_and_compare("timeout");
    rand_fields();
    make_frame(1'b0);
    send_from(0, 2, 1'b0);
    flush_and_compare("after_timeout");
    rand_fields();
    make_frame(1'b0);
    for (int i = 0; i < 8; i++) send_byte(frame_q[i]);
    idle(63);
    send_from(8, 0, 1'b0);
    flush_and_compare("stall63");

    // 5: back-to-back frames.
    rand_fields();
    make_frame(1'b0);
    send_from(0, 0, 1'b0);
    rand_fields();
    make_frame(1'b0);
    send_from(0, 0, 1'b0);
    idle(2);
    if (got_q.size() == 2) begin
      t0 = got_q[0].cyc;
      t1 = got_q[1].cyc;
      check("b2b.spacing", 64'(t1 - t0), 64'(FRAME_LEN));
    end else begin
      check("b2b.pulses", 64'(got_q.size()), 64'd2);
    end
    flush_and_compare("b2b");

    // Random traffic: junk, gaps, occasional bad checksums, back-to-back runs.
    for (int n = 0; n < 24; n++) begin
      bit bad;
      for (int j = $urandom_range(2, 0); j > 0; j--) begin
        jb = 8'($urandom);
        if (jb == 8'hA5) jb = 8'h5A;
        send_byte(jb);
      end
      bad = CK_EN && ($urandom_range(3, 0) == 0);
      rand_fields();
      make_frame(bad);
      send_from(0, $urandom_range(3, 0), bad);
    end
    flush_and_compare("random");

    // 6: reset in the middle of the payload.
    rand_fields();
    make_frame(1'b0);
    for (int i = 0; i < 12; i++) send_byte(frame_q[i]);
    apply_reset();
    check_reset_state("mid_reset");
    reset = 1'b0;
    rand_fields();
    make_frame(1'b0);
    send_from(0, 1, 1'b0);
    flush_and_compare("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
